// File: rtl/conbus_arb_wdt.sv
// conbus_arb_wdt
// ---------------------------------------------------------------------------
// Round-robin bus arbiter for a shared conbus with a stalled-strobe watchdog.
// The arbiter grants one master at a time and never preempts it.
// While the granted master's strobe is pending without an ack, a 16-bit
// counter runs. When TIMEOUT stalled cycles have elapsed, the arbiter issues
// one synthetic ack cycle (timeout_ack) to end the transfer. It also records
// the offending master and sets a sticky error flag.
//
// Parameters
//   NMASTERS  number of bus masters (2..8)
//   TIMEOUT   stalled-strobe cycles before forced termination (2..65535)
//
// Ports
//   sys_clk         in   sole clock, rising edge
//   sys_rst         in   asynchronous active-high reset
//   req             in   per-master cyc, bit i = master i requests the bus
//   i_stb           in   shared-bus strobe (after the master mux)
//   i_ack           in   OR of all slave acks
//   err_clr         in   one-cycle pulse clearing timeout_err
//   gnt             out  binary index of the granted master (registered)
//   gnt_valid       out  high while a grant is active
//   timeout_ack     out  one-cycle pulse OR'd into the granted master's ack
//   timeout_err     out  sticky timeout flag
//   timeout_master  out  master that was granted at the most recent timeout
// ---------------------------------------------------------------------------
module conbus_arb_wdt #(
  parameter int NMASTERS = 5,
  parameter int TIMEOUT  = 1023
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NMASTERS-1:0] req,
  input  logic                i_stb,
  input  logic                i_ack,
  input  logic                err_clr,
  output logic [2:0]          gnt,
  output logic                gnt_valid,
  output logic                timeout_ack,
  output logic                timeout_err,
  output logic [2:0]          timeout_master
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  // Counter value seen in the final stalled cycle before the forced ack.
  localparam logic [15:0] WDT_LAST   = 16'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_RESET = 3'(NMASTERS - 1);

  state_t      state_reg;
  logic [2:0]  gnt_reg;
  logic        gnt_valid_reg;
  logic        timeout_ack_reg;
  logic        timeout_err_reg;
  logic [2:0]  timeout_master_reg;
  logic [15:0] wdt_cnt_reg;
  logic [2:0]  last_reg;

  // Round-robin search: first set bit starting at base+1, wrapping around.
  // The base index itself is considered last.
  function automatic logic [2:0] rr_pick(input logic [NMASTERS-1:0] r,
                                         input logic [2:0]          base);
    logic [2:0] pick;
    int         idx;
    pick = base;
    // Walk from the farthest candidate to the nearest one.
    // The nearest set bit is written last, so it wins.
    for (int k = NMASTERS; k >= 1; k--) begin
      idx = (int'(base) + k) % NMASTERS;
      if (r[idx]) pick = 3'(idx);
    end
    return pick;
  endfunction

  // req[gnt] built without a variable index.
  // This keeps the selection in range for any NMASTERS.
  logic [NMASTERS-1:0] cur_hit;
  for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_cur_hit
    assign cur_hit[gi] = req[gi] & (gnt_reg == 3'(gi));
  end

  logic       cur_req;
  logic       any_req;
  logic       stalled;
  logic [2:0] pick_from_last;
  logic [2:0] pick_from_gnt;

  assign cur_req        = |cur_hit;
  assign any_req        = |req;
  assign stalled        = i_stb & ~i_ack;
  assign pick_from_last = rr_pick(req, last_reg);
  assign pick_from_gnt  = rr_pick(req, gnt_reg);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg          <= S_IDLE;
      gnt_reg            <= 3'd0;
      gnt_valid_reg      <= 1'b0;
      timeout_ack_reg    <= 1'b0;
      timeout_err_reg    <= 1'b0;
      timeout_master_reg <= 3'd0;
      wdt_cnt_reg        <= 16'd0;
      last_reg           <= LAST_RESET;
    end else begin
      timeout_ack_reg <= 1'b0;
      // A timeout raised in this same cycle overrides the clear below.
      if (err_clr) timeout_err_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          wdt_cnt_reg <= 16'd0;
          if (any_req) begin
            gnt_reg       <= pick_from_last;
            last_reg      <= pick_from_last;
            gnt_valid_reg <= 1'b1;
            state_reg     <= S_GRANT;
          end else begin
            gnt_valid_reg <= 1'b0;
          end
        end

        S_GRANT: begin
          if (!cur_req) begin
            // The owner released the bus, so hand it over with no idle gap.
            // With no other requester, fall back to IDLE.
            wdt_cnt_reg <= 16'd0;
            if (any_req) begin
              gnt_reg  <= pick_from_gnt;
              last_reg <= pick_from_gnt;
            end else begin
              gnt_valid_reg <= 1'b0;
              state_reg     <= S_IDLE;
            end
          end else if (stalled) begin
            if (wdt_cnt_reg == WDT_LAST) begin
              state_reg          <= S_TIMEOUT;
              wdt_cnt_reg        <= 16'd0;
              timeout_ack_reg    <= 1'b1;
              timeout_err_reg    <= 1'b1;
              timeout_master_reg <= gnt_reg;
            end else begin
              wdt_cnt_reg <= wdt_cnt_reg + 16'd1;
            end
          end else begin
            // An ack, or no pending strobe, restarts the stall window.
            wdt_cnt_reg <= 16'd0;
          end
        end

        S_TIMEOUT: begin
          // timeout_ack was high for this one cycle.
          // Resume the grant, or re-arbitrate if the owner has gone.
          wdt_cnt_reg <= 16'd0;
          if (cur_req) begin
            state_reg <= S_GRANT;
          end else if (any_req) begin
            gnt_reg   <= pick_from_gnt;
            last_reg  <= pick_from_gnt;
            state_reg <= S_GRANT;
          end else begin
            gnt_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end

        default: begin
          state_reg     <= S_IDLE;
          gnt_valid_reg <= 1'b0;
          wdt_cnt_reg   <= 16'd0;
        end
      endcase
    end
  end

  assign gnt            = gnt_reg;
  assign gnt_valid      = gnt_valid_reg;
  assign timeout_ack    = timeout_ack_reg;
  assign timeout_err    = timeout_err_reg;
  assign timeout_master = timeout_master_reg;

endmodule

// File: tb/tb_conbus_arb_wdt.sv
// tb_conbus_arb_wdt
// Directed bench for conbus_arb_wdt with NMASTERS=5 and TIMEOUT=8.
// Each step pushes the expected output tuple (gnt, gnt_valid, timeout_ack,
// timeout_err, timeout_master) onto a queue as stimulus is driven.
// After the clock edge, the tuple is popped and compared with the outputs.
// Inputs are driven, and outputs sampled, on the falling edge.
module tb_conbus_arb_wdt;

  localparam int NM = 5;
  localparam int TO = 8;

  logic          sys_clk;
  logic          sys_rst;
  logic [NM-1:0] req;
  logic          i_stb;
  logic          i_ack;
  logic          err_clr;
  logic [2:0]    gnt;
  logic          gnt_valid;
  logic          timeout_ack;
  logic          timeout_err;
  logic [2:0]    timeout_master;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  conbus_arb_wdt #(.NMASTERS(NM), .TIMEOUT(TO)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .req            (req),
    .i_stb          (i_stb),
    .i_ack          (i_ack),
    .err_clr        (err_clr),
    .gnt            (gnt),
    .gnt_valid      (gnt_valid),
    .timeout_ack    (timeout_ack),
    .timeout_err    (timeout_err),
    .timeout_master (timeout_master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic expect_out(input int g, input int v, input int ta, input int te, input int tm);
    exp_q.push_back(16'(g));
    exp_q.push_back(16'(v));
    exp_q.push_back(16'(ta));
    exp_q.push_back(16'(te));
    exp_q.push_back(16'(tm));
  endtask

  task automatic check_one(input string tag, input logic [15:0] obs);
    logic [15:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed %0d but scoreboard empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
    end
  endtask

  task automatic check_out(input string tag);
    check_one({tag, "/gnt"},            16'(gnt));
    check_one({tag, "/gnt_valid"},      16'(gnt_valid));
    check_one({tag, "/timeout_ack"},    16'(timeout_ack));
    check_one({tag, "/timeout_err"},    16'(timeout_err));
    check_one({tag, "/timeout_master"}, 16'(timeout_master));
    $display("step %-20s gnt=%0d v=%0d tack=%0d terr=%0d tmaster=%0d",
             tag, gnt, gnt_valid, timeout_ack, timeout_err, timeout_master);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    req     = '0;
    i_stb   = 1'b0;
    i_ack   = 1'b0;
    err_clr = 1'b0;
    step(2);
    sys_rst = 1'b0;
  endtask

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    sys_rst = 1'b1;
    req     = '0;
    i_stb   = 1'b0;
    i_ack   = 1'b0;
    err_clr = 1'b0;
    step(2);
    expect_out(0, 0, 0, 0, 0); check_out("reset");

    // First arbitration after reset, then a hand-off without a gap, then idle.
    sys_rst = 1'b0;
    req = 5'b00110;
    expect_out(1, 1, 0, 0, 0); step(1); check_out("arb_first");
    req = 5'b00100;
    expect_out(2, 1, 0, 0, 0); step(1); check_out("arb_handoff");
    req = 5'b00000;
    expect_out(2, 0, 0, 0, 0); step(1); check_out("idle_hold");

    // Lock: master 0 keeps the bus for 100 cycles despite the others.
    do_reset();
    req = 5'b11111;
    expect_out(0, 1, 0, 0, 0); step(1); check_out("lock_grant");
    for (int i = 0; i < 100; i++) begin
      expect_out(0, 1, 0, 0, 0); step(1); check_out("lock_hold");
    end
    req = 5'b11110;
    expect_out(1, 1, 0, 0, 0); step(1); check_out("lock_release");
    req = 5'b00000; step(1);

    // Rotation: each owner drops cyc for one cycle after 3 granted cycles.
    do_reset();
    req = 5'b11111;
    expect_out(0, 1, 0, 0, 0); step(1); check_out("rot_grant");
    for (int i = 0; i < NM; i++) begin
      repeat (2) begin
        expect_out(i, 1, 0, 0, 0); step(1); check_out("rot_hold");
      end
      req[i] = 1'b0;
      expect_out((i + 1) % NM, 1, 0, 0, 0); step(1);
      req[i] = 1'b1;
      check_out("rot_next");
    end
    req = 5'b00000; step(1);

    // Stall: master 3 strobes with no ack; the forced ack comes on stall cycle 8.
    do_reset();
    req = 5'b01000;
    expect_out(3, 1, 0, 0, 0); step(1); check_out("stall_grant");
    i_stb = 1'b1;
    for (int i = 0; i < TO - 1; i++) begin
      expect_out(3, 1, 0, 0, 0); step(1); check_out("stall_count");
    end
    expect_out(3, 1, 1, 1, 3); step(1); check_out("stall_timeout");
    i_stb = 1'b0;
    expect_out(3, 1, 0, 1, 3); step(1); check_out("stall_pulse_end");
    err_clr = 1'b1;
    expect_out(3, 1, 0, 0, 3); step(1); err_clr = 1'b0; check_out("err_clr");

    // A set and err_clr in the same cycle: the set wins.
    i_stb = 1'b1;
    for (int i = 0; i < TO - 1; i++) begin
      expect_out(3, 1, 0, 0, 3); step(1); check_out("setwin_count");
    end
    err_clr = 1'b1;
    expect_out(3, 1, 1, 1, 3); step(1); err_clr = 1'b0; i_stb = 1'b0;
    check_out("set_wins");
    expect_out(3, 1, 0, 1, 3); step(1); check_out("set_wins_after");
    err_clr = 1'b1;
    expect_out(3, 1, 0, 0, 3); step(1); err_clr = 1'b0; check_out("err_clr2");

    // Race: ack on the 8th stalled cycle wins and restarts the window.
    i_stb = 1'b1;
    for (int i = 0; i < TO - 1; i++) begin
      expect_out(3, 1, 0, 0, 3); step(1); check_out("race_count");
    end
    i_ack = 1'b1;
    expect_out(3, 1, 0, 0, 3); step(1); i_ack = 1'b0; check_out("race_ack_wins");
    for (int i = 0; i < TO - 1; i++) begin
      expect_out(3, 1, 0, 0, 3); step(1); check_out("race_recount");
    end
    expect_out(3, 1, 1, 1, 3); step(1); check_out("race_late_timeout");
    i_stb = 1'b0;
    expect_out(3, 1, 0, 1, 3); step(1); check_out("race_pulse_end");

    // Asynchronous reset at stall count 5 (timeout_err and timeout_master are set).
    i_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_out(3, 1, 0, 1, 3); step(1); check_out("rst_stall_count");
    end
    #2 sys_rst = 1'b1;
    #1 expect_out(0, 0, 0, 0, 0); check_out("async_reset");
    req = 5'b00000;
    step(1);
    sys_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_out(0, 0, 0, 0, 0); step(1); check_out("post_rst_quiet");
    end
    // After reset, master 0 wins first and the stall window starts from zero.
    req = 5'b11111;
    expect_out(0, 1, 0, 0, 0); step(1); check_out("post_rst_arb");
    for (int i = 0; i < TO - 1; i++) begin
      expect_out(0, 1, 0, 0, 0); step(1); check_out("post_rst_count");
    end
    expect_out(0, 1, 1, 1, 0); step(1); check_out("post_rst_timeout");
    i_stb = 1'b0;
    req   = 5'b00000;
    step(2);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
